// File: rtl/tlc_sensor_conditioner.sv
// Detector front end: 2-flop sync, debounce, per-channel call memory, stuck-on flags.
// Sensor rises/falls DEBOUNCE+2 edges after raw; all outputs registered, no backpressure.
package light_package;
   typedef enum logic [1:0] {red = 2'd0, yellow = 2'd1, green = 2'd2} colors;
endpackage

module tlc_sensor_conditioner #(
   parameter int         DEBOUNCE    = 3,
   parameter int         STUCK_LIMIT = 600,
   parameter logic [4:0] LOCK_MASK   = 5'b11111
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 e_str_raw,
   input  logic                 w_str_raw,
   input  logic                 e_left_raw,
   input  logic                 w_left_raw,
   input  logic                 ns_raw,
   input  light_package::colors e_str_light,
   input  light_package::colors w_str_light,
   input  light_package::colors e_left_light,
   input  light_package::colors w_left_light,
   input  light_package::colors ns_light,
   output logic                 e_str_sensor,
   output logic                 w_str_sensor,
   output logic                 e_left_sensor,
   output logic                 w_left_sensor,
   output logic                 ns_sensor,
   output logic [4:0]           fault
);
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int RW = $clog2(STUCK_LIMIT + 1);

   logic [4:0]           raw;
   logic [4:0]           call;
   logic [4:0]           flt;
   light_package::colors light [5];

   assign raw      = {ns_raw, w_left_raw, e_left_raw, w_str_raw, e_str_raw};
   assign light[0] = e_str_light;
   assign light[1] = w_str_light;
   assign light[2] = e_left_light;
   assign light[3] = w_left_light;
   assign light[4] = ns_light;

   generate
      for (genvar g = 0; g < 5; g++) begin : g_ch
         localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
         localparam logic [RW-1:0] RUN_MAX = RW'(STUCK_LIMIT);

         logic          s1, s2, pres, pres_n;
         logic          call_q, call_n, flt_q, flt_n, served;
         logic [CW-1:0] cnt, cnt_n;
         logic [RW-1:0] run, run_n;

         assign served = (light[g] == light_package::green);

         always_comb begin
            pres_n = pres;
            cnt_n  = '0;
            if (s2 != pres) begin
               if (cnt == CNT_MAX) pres_n = s2;
               else                cnt_n  = cnt + 1'b1;
            end
            run_n = '0;
            if (pres_n) run_n = (run == RUN_MAX) ? run : run + 1'b1;
            // Fault is sticky and holds the call high (recall mode).
            flt_n = flt_q | (run_n == RUN_MAX);
            if (LOCK_MASK[g]) call_n = pres_n | flt_n | (call_q & ~served);
            else              call_n = pres_n | flt_n;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1     <= 1'b0;
               s2     <= 1'b0;
               pres   <= 1'b0;
               cnt    <= '0;
               run    <= '0;
               flt_q  <= 1'b0;
               call_q <= 1'b0;
            end else begin
               s1     <= raw[g];
               s2     <= s1;
               pres   <= pres_n;
               cnt    <= cnt_n;
               run    <= run_n;
               flt_q  <= flt_n;
               call_q <= call_n;
            end
         end

         assign call[g] = call_q;
         assign flt[g]  = flt_q;
      end
   endgenerate

   assign e_str_sensor  = call[0];
   assign w_str_sensor  = call[1];
   assign e_left_sensor = call[2];
   assign w_left_sensor = call[3];
   assign ns_sensor     = call[4];
   assign fault         = flt;
endmodule

// File: doc/tlc_sensor_conditioner.md
# tlc_sensor_conditioner

Upstream stage of the 5-approach traffic light controller. It turns raw vehicle-detector inputs into the five clean sensor signals the controller consumes: e_str, w_str, e_left, w_left and ns. For each approach it synchronizes and debounces the raw input, then holds a locking call until the matching light has served it. It also flags detectors that have been stuck on.

## Interface
- DEBOUNCE, 3: consecutive synchronized cycles a new level must persist before it is accepted; legal range is ≥1.
- STUCK_LIMIT, 600: consecutive cycles of accepted presence after which a channel is declared faulty; must be ≥2.
- LOCK_MASK, 5'b11111: per-channel call memory enable. A 1 selects a locking call; a 0 makes the call follow accepted presence.
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw  in  1 each  raw detector levels, asynchronous to clk.
- e_str_light, w_str_light, e_left_light, w_left_light, ns_light  in  colors (light_package)  feedback from the controller's light outputs.
- e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor  out  1 each  registered call to the controller.
- fault  out  5  sticky stuck-detector flags, one bit per channel.

Channel index i, used for fault and LOCK_MASK:
- 0 = e_str
- 1 = w_str
- 2 = e_left
- 3 = w_left
- 4 = ns

## Operation
Each channel has its own identical datapath.
- **Synchronizer:** two flops, raw → s1 → s2.
- **Debounce:** a counter cnt of width $clog2(DEBOUNCE) (minimum 1 bit) and an accepted level pres.
  - If s2 == pres: cnt ← 0.
  - Else if cnt == DEBOUNCE−1: pres ← s2 and cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any glitch shorter than DEBOUNCE cycles at s2 resets cnt and is never accepted.
- **Served condition:** served = (light == green). Yellow and red never count as service.
- **Call register** (drives the sensor output); pres_n is the value pres takes this edge:
  - Locking channel: call ← pres_n | fault_n | (call & ~served).
  - Non-locking channel: call ← pres_n | fault_n.
  - Effect: a vehicle that arrives and leaves while the light is red keeps its call until the first edge on which the light is green and pres_n = 0.
- **Stuck detector:** a run counter of width $clog2(STUCK_LIMIT+1).
  - Increments while pres_n = 1, saturating at STUCK_LIMIT.
  - Clears when pres_n = 0.
  - The edge on which run becomes STUCK_LIMIT sets fault[i].
  - fault[i] stays set until reset and forces call high (recall mode). The controller's 9-cycle max-green bounds any starvation this causes.
- **Independence:** channels never interact, and all five update on the same edge.

## Timing
- **Reset values:** all outputs are 0 (five sensor outputs and fault = 5'b0). Internal s1, s2, pres, cnt, call and run are also 0.
- **Reset assertion:** takes effect asynchronously, mid-cycle, including in the middle of a debounce count or with a call pending.
- **Reset release:** the first active edge is the first clk edge after reset falls.
- **Rise latency:** raw rises before edge 1 and stays stable. Then s1 = 1 at edge 1, s2 = 1 at edge 2, and pres and sensor = 1 at edge 2+DEBOUNCE (edge 5 with defaults).
- **Fall latency:** the same, so pres falls at edge 2+DEBOUNCE after raw falls.
  - If the light is green at that edge, the sensor falls on that same edge.
  - Otherwise the sensor holds until the first edge with light == green.
- **Simultaneous arrival and service:** if pres_n = 1 and served = 1 on the same edge, the call stays 1 (presence wins).
- **Stuck timing:** fault[i] rises STUCK_LIMIT edges after pres first became 1 (the pres rise edge counts as run = 1), with no intervening drop.
- **Saturation:** the run counter saturates and never wraps.
- **Outputs:** all outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE=3 and STUCK_LIMIT=20 unless stated.
- **Reset, then rise latency:** pulse reset asynchronously mid-cycle → all outputs are 0 immediately. Then hold e_str_raw = 1 from before edge 1 → e_str_sensor = 0 through edge 4 and = 1 after edge 5; the other four sensors stay 0.
- **Glitch rejection:** ns_raw high for 2 cycles (s2 high for 2 cycles), then low → ns_sensor never asserts and cnt returns to 0.
- **Locking memory:** w_left_raw high for 10 cycles while w_left_light = red, then low → w_left_sensor stays 1 indefinitely. Drive w_left_light = green → sensor drops at that edge. Drive yellow instead of green → sensor stays 1.
- **Non-locking channel:** LOCK_MASK = 5'b11110 and the same stimulus on e_str → e_str_sensor falls 5 edges after raw falls, with the light red.
- **Stuck detector:** e_left_raw held high → fault = 5'b00100 exactly 20 edges after e_left_sensor rose. Raw then low and light green → sensor stays 1 and fault stays set. Reset clears both.
- **Reset mid-debounce:** raw high for 4 edges, reset pulsed, raw kept high → sensor rises only at edge 5 counted from the first edge after reset release.
